// File: rtl/led_show_pkg.sv
// Shared types for the LED show: mode encoding, one-hot LEDG values and mode ordering.
package led_show_pkg;

    typedef enum logic [1:0] {
        MODE_SWEEP = 2'd0,
        MODE_FILL  = 2'd1,
        MODE_BLINK = 2'd2
    } mode_e;

    localparam logic [2:0] LEDG_SWEEP = 3'b001;
    localparam logic [2:0] LEDG_FILL  = 3'b010;
    localparam logic [2:0] LEDG_BLINK = 3'b100;

    function automatic mode_e next_mode(input mode_e m);
        case (m)
            MODE_SWEEP: return MODE_FILL;
            MODE_FILL:  return MODE_BLINK;
            default:    return MODE_SWEEP;
        endcase
    endfunction

    function automatic logic [2:0] mode_ledg(input mode_e m);
        case (m)
            MODE_SWEEP: return LEDG_SWEEP;
            MODE_FILL:  return LEDG_FILL;
            default:    return LEDG_BLINK;
        endcase
    endfunction

endpackage

// File: rtl/led_show_sequencer_if.sv
// Board-side signals of the LED show: switches and key in, LED banks out.
interface led_show_sequencer_if #(
    parameter int WIDTH = 18
);
    logic             SW0;
    logic             SW1;
    logic             KEY1_N;
    logic [WIDTH-1:0] LEDR;
    logic [2:0]       LEDG;

    modport master (output SW0, SW1, KEY1_N, input LEDR, LEDG);
    modport slave  (input SW0, SW1, KEY1_N, output LEDR, LEDG);
endinterface

// File: rtl/led_tick_gen.sv
// Step-tick prescaler; period picked by the synchronized speed switch.
module led_tick_gen #(
    parameter int FAST_DIV = 5_000_000,
    parameter int SLOW_DIV = 25_000_000
) (
    input  logic CLOCK_50,
    input  logic RESET_N,
    input  logic sw0_raw,
    input  logic clr,
    output logic tick
);
    localparam int MAXD = (FAST_DIV > SLOW_DIV) ? FAST_DIV : SLOW_DIV;
    localparam int CW   = (MAXD > 1) ? $clog2(MAXD) : 1;
    localparam logic [CW-1:0] FAST_LAST = CW'(FAST_DIV - 1);
    localparam logic [CW-1:0] SLOW_LAST = CW'(SLOW_DIV - 1);

    logic [1:0]    sw0_sync;
    logic [CW-1:0] cnt;
    logic [CW-1:0] last;

    // >= rather than == so a switch to a shorter period never skips a wrap
    assign last = sw0_sync[1] ? FAST_LAST : SLOW_LAST;
    assign tick = (cnt >= last);

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sw0_sync <= '0;
            cnt      <= '0;
        end else begin
            sw0_sync <= {sw0_sync[0], sw0_raw};
            if (clr || tick) cnt <= '0;
            else             cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/led_show_sequencer.sv
// LED show controller: SWEEP / FILL / BLINK on LEDR, one-hot mode on LEDG.
// Modes advance after their pass count (when SW1 enables it) or on a debounced KEY1 press.
module led_show_sequencer
    import led_show_pkg::*;
#(
    parameter int WIDTH       = 18,
    parameter int FAST_DIV    = 5_000_000,
    parameter int SLOW_DIV    = 25_000_000,
    parameter int PASSES      = 2,
    parameter int BLINK_COUNT = 4,
    parameter int DEBOUNCE    = 1_000_000
) (
    input  logic                CLOCK_50,
    input  logic                RESET_N,
    led_show_sequencer_if.slave io
);
    localparam int PW      = $clog2(WIDTH);
    localparam int LW      = $clog2(WIDTH + 1);
    localparam int LAP_MAX = (PASSES > BLINK_COUNT) ? 2 * PASSES : 2 * BLINK_COUNT;
    localparam int NW      = $clog2(LAP_MAX + 1);
    localparam int DW      = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [WIDTH-1:0] SWEEP_ONE = WIDTH'(1);
    localparam logic [WIDTH:0]   FILL_ONE  = (WIDTH + 1)'(1);

    logic          tick;
    logic [1:0]    sw1_sync;
    logic [1:0]    key_sync;
    logic          key_prev;
    logic [DW-1:0] lock;
    logic          press;

    // Pattern state; laps is the shared pass/reversal/phase counter of the active mode
    mode_e         mode,  n_mode;
    logic [PW-1:0] pos,   n_pos;
    logic          left,  n_left;
    logic [LW-1:0] level, n_level;
    logic          grow,  n_grow;
    logic          phase, n_phase;
    logic [NW-1:0] laps,  n_laps;
    logic          done;

    logic [WIDTH-1:0] ledr_q, n_ledr;
    logic [2:0]       ledg_q;
    logic [WIDTH:0]   fill_w;

    led_tick_gen #(
        .FAST_DIV (FAST_DIV),
        .SLOW_DIV (SLOW_DIV)
    ) u_tick (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .sw0_raw  (io.SW0),
        .clr      (press),
        .tick     (tick)
    );

    assign press = key_prev & ~key_sync[1] & (lock == '0);

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sw1_sync <= '0;
            key_sync <= 2'b11;
            key_prev <= 1'b1;
            lock     <= '0;
        end else begin
            sw1_sync <= {sw1_sync[0], io.SW1};
            key_sync <= {key_sync[0], io.KEY1_N};
            key_prev <= key_sync[1];
            if (press)            lock <= DW'(DEBOUNCE - 1);
            else if (lock != '0)  lock <= lock - 1'b1;
        end
    end

    always_comb begin
        n_mode  = mode;
        n_pos   = pos;
        n_left  = left;
        n_level = level;
        n_grow  = grow;
        n_phase = phase;
        n_laps  = laps;
        done    = 1'b0;
        if (tick) begin
            unique case (mode)
                MODE_SWEEP: begin
                    if (left) begin
                        if (pos == PW'(WIDTH - 1)) begin
                            n_left = 1'b0;
                            n_pos  = PW'(WIDTH - 2);
                            n_laps = laps + 1'b1;
                        end else begin
                            n_pos = pos + 1'b1;
                        end
                    end else if (pos == '0) begin
                        n_laps = laps + 1'b1;
                        if (n_laps == NW'(2 * PASSES)) begin
                            done = 1'b1;
                        end else begin
                            n_left = 1'b1;
                            n_pos  = PW'(1);
                        end
                    end else begin
                        n_pos = pos - 1'b1;
                    end
                end
                MODE_FILL: begin
                    if (grow) begin
                        if (level == LW'(WIDTH)) begin
                            n_grow  = 1'b0;
                            n_level = LW'(WIDTH - 1);
                        end else begin
                            n_level = level + 1'b1;
                        end
                    end else if (level == '0) begin
                        n_laps = laps + 1'b1;
                        if (n_laps == NW'(PASSES)) begin
                            done = 1'b1;
                        end else begin
                            n_grow  = 1'b1;
                            n_level = LW'(1);
                        end
                    end else begin
                        n_level = level - 1'b1;
                    end
                end
                default: begin
                    n_laps  = laps + 1'b1;
                    n_phase = ~phase;
                    if (n_laps == NW'(2 * BLINK_COUNT)) done = 1'b1;
                end
            endcase
        end
        // Key path wins over completion so a coincident press advances exactly one mode
        if (press || done) begin
            n_mode  = (press || sw1_sync[1]) ? next_mode(mode) : mode;
            n_pos   = '0;
            n_left  = 1'b1;
            n_level = '0;
            n_grow  = 1'b1;
            n_phase = 1'b1;
            n_laps  = '0;
        end
    end

    always_comb begin
        fill_w = (FILL_ONE << n_level) - FILL_ONE;
        unique case (n_mode)
            MODE_SWEEP: n_ledr = SWEEP_ONE << n_pos;
            MODE_FILL:  n_ledr = fill_w[WIDTH-1:0];
            default:    n_ledr = n_phase ? '1 : '0;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            mode   <= MODE_SWEEP;
            pos    <= '0;
            left   <= 1'b1;
            level  <= '0;
            grow   <= 1'b1;
            phase  <= 1'b1;
            laps   <= '0;
            ledr_q <= SWEEP_ONE;
            ledg_q <= LEDG_SWEEP;
        end else begin
            mode   <= n_mode;
            pos    <= n_pos;
            left   <= n_left;
            level  <= n_level;
            grow   <= n_grow;
            phase  <= n_phase;
            laps   <= n_laps;
            ledr_q <= n_ledr;
            ledg_q <= mode_ledg(n_mode);
        end
    end

    assign io.LEDR = ledr_q;
    assign io.LEDG = ledg_q;
endmodule
